mem_access_unit: RTL and testbench

Memory-stage access controller for the 5-stage ARM-style pipeline. Sits between the EXE/MEM pipeline register and the external data memory. It turns the EXE stage's ALU result (address), Rm value (store data) and memory read/write enables into a req/ack memory transaction. It asserts `freeze` to stall the upstream pipeline until the transaction completes, then presents the load result to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller for a 5-stage ARM-style pipeline. Converts
// the EXE/MEM register's load/store command, byte address (ALU_result) and
// store data (Val_Rm) into a single req/ack transaction on the data-memory
// port. Holds the upstream pipeline with `freeze` until the transaction has
// finished, then presents load data on MEM_result.
//
// Optional feature (compile-time macro): MEM_ALIGN_CHECK_EN
//   When defined, a command whose byte address is not word aligned issues no
//   memory request. Instead it flags mem_err and goes straight to DONE.
//   When undefined, the low two address bits are simply dropped.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN  load / store command (both set -> treated as store)
//   ALU_result          byte address from EXE
//   Val_Rm              store data
//   mem_req             registered request, high for the whole REQ phase
//   mem_we              1 = write, 0 = read (valid while mem_req)
//   mem_addr            word address (valid while mem_req)
//   mem_wdata           write data (valid while mem_req)
//   mem_ack             single-cycle completion pulse (ignored outside REQ)
//   mem_rdata           read data, valid in the mem_ack cycle
//   MEM_result          registered load data, held until the next load
//   freeze              combinational stall for PC, IF/ID, ID/EX, EXE/MEM
//   mem_err             registered abort flag, held until the next access
//   fsm_state           debug view of the controller state
//                       (0 = IDLE, 1 = REQ, 2 = DONE)
//
// Handshake: mem_req rises on the edge that leaves IDLE and stays high, with
// mem_we/mem_addr/mem_wdata frozen, until the edge that samples mem_ack=1 or
// the edge on which the wait budget runs out. mem_ack is honoured only while
// in REQ; one request is outstanding at a time.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       Val_Rm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MEM_result,
    output logic              freeze,
    output logic              mem_err,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The wait counter is cleared on entry to REQ, so the first REQ cycle sees
    // 0 and the abort edge is the one where the count reaches TIMEOUT-1. That
    // gives exactly TIMEOUT cycles of mem_req before giving up.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic       cmd;
    logic       misaligned;
    logic       start_req;
    logic       align_abort;
    logic       wait_expired;
    logic [7:0] wait_cnt;

    assign cmd          = MEM_R_EN | MEM_W_EN;
    assign wait_expired = (wait_cnt == LAST_WAIT);
    assign fsm_state    = state;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (ALU_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and stall. DONE always drops freeze for one cycle so the
    // completed instruction can leave the MEM stage; it never starts another
    // request, which keeps back-to-back accesses at least three cycles apart.
    // -------------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        freeze      = 1'b0;
        start_req   = 1'b0;
        align_abort = 1'b0;
        case (state)
            IDLE: begin
                if (cmd) begin
                    freeze = 1'b1;
                    if (misaligned) begin
                        align_abort = 1'b1;
                        next_state  = DONE;
                    end else begin
                        start_req  = 1'b1;
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                freeze = 1'b1;
                if (mem_ack || wait_expired) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory port, wait counter and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            MEM_result <= '0;
            mem_err    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (start_req) begin
                mem_req   <= 1'b1;
                // A command with both enables set is a store.
                mem_we    <= MEM_W_EN;
                // 32-bit modulo subtraction; wrap-around below BASE_ADDR is
                // silent and only the low ADDR_W bits of the word index are kept.
                mem_addr  <= ADDR_W'((ALU_result - 32'(BASE_ADDR)) >> 2);
                mem_wdata <= Val_Rm;
                wait_cnt  <= '0;
                mem_err   <= 1'b0;
            end

            if (align_abort) begin
                mem_err <= 1'b1;
            end

            if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
                // An ack on the expiry edge still counts as a success.
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!mem_we) begin
                        MEM_result <= mem_rdata;
                    end
                end else if (wait_expired) begin
                    mem_req <= 1'b0;
                    mem_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_unit (instantiated with TIMEOUT = 4).
// Fixed vector table for the directed cases, hand-written sequences for reset
// during a transaction and stray acks, then randomized accesses checked
// against a small behavioural model of the controller.
// Inputs change 1 ns after the rising edge (mem_ack is raised at the falling
// edge of the REQ cycle it belongs to); outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TO = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] MEM_result;
    logic        freeze;
    logic        mem_err;
    logic [1:0]  fsm_state;

    mem_access_unit #(
        .BASE_ADDR(1024),
        .ADDR_W   (16),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .ALU_result(ALU_result),
        .Val_Rm    (Val_Rm),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .MEM_result(MEM_result),
        .freeze    (freeze),
        .mem_err   (mem_err),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_result;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] alu;
        logic [31:0] val;
        int          delay;       // REQ cycle carrying mem_ack; 0 = never
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
        logic        exp_err;
        int          exp_freeze;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver: one complete access ----------------
    task automatic run_access(input vec_t v, input string tag);
        int          fcnt = 0;
        int          rcnt = 0;
        bit          done = 0;
        bit          stable = 1;
        logic [15:0] a = '0;
        logic        we = 1'b0;
        logic [31:0] wd = '0;
        logic [31:0] exp_r;

        exp_q.push_back(v.exp_result);
        @(posedge clk); #1;
        MEM_R_EN   = v.r;
        MEM_W_EN   = v.w;
        ALU_result = v.alu;
        Val_Rm     = v.val;
        mem_rdata  = v.rdata;
        mem_ack    = 1'b0;

        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (fsm_state == ST_DONE) begin
                done  = 1;
                exp_r = exp_q.pop_front();
                check({tag, " freeze_in_done"}, {31'b0, freeze}, 32'd0);
                check({tag, " req_in_done"}, {31'b0, mem_req}, 32'd0);
                check({tag, " result"}, MEM_result, exp_r);
                check({tag, " err"}, {31'b0, mem_err}, {31'b0, v.exp_err});
            end else begin
                if (freeze) fcnt++;
                if (mem_req) begin
                    rcnt++;
                    if (rcnt == 1) begin
                        a = mem_addr; we = mem_we; wd = mem_wdata;
                    end else if (a !== mem_addr || we !== mem_we || wd !== mem_wdata) begin
                        stable = 0;
                    end
                    if (rcnt == v.delay) mem_ack = 1'b1;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end

        check({tag, " done_reached"}, {31'b0, done}, 32'd1);
        if (!done) void'(exp_q.pop_front());
        check({tag, " freeze_cycles"}, fcnt, v.exp_freeze);
        check({tag, " req_cycles"}, rcnt, v.exp_req ? v.exp_freeze - 1 : 0);
        if (v.exp_req && rcnt > 0) begin
            check({tag, " addr"}, {16'b0, a}, v.exp_addr);
            check({tag, " we"}, {31'b0, we}, {31'b0, v.exp_we});
            check({tag, " wdata"}, wd, v.exp_wdata);
            check({tag, " req_stable"}, {31'b0, stable}, 32'd1);
        end

        // Pipeline advances in DONE: command goes away, controller returns idle.
        @(posedge clk); #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        check({tag, " back_to_idle"}, {30'b0, fsm_state}, {30'b0, ST_IDLE});
    endtask

    // ---------------- reference model for random accesses ----------------
    function automatic vec_t make_random();
        vec_t        v;
        logic [31:0] d;
        bit          acked;
        bit          mis;
        v.r     = 1'($urandom_range(0, 1));
        v.w     = 1'($urandom_range(0, 1));
        if (!v.r && !v.w) v.r = 1'b1;
        v.alu   = $urandom();
        v.val   = $urandom();
        v.rdata = $urandom();
        v.delay = $urandom_range(0, 6);
        d          = v.alu - 32'd1024;
        v.exp_addr = (d / 4) % 65536;
        v.exp_we   = v.w;
        v.exp_wdata = v.val;
        acked = (v.delay >= 1) && (v.delay <= TO);
        mis   = 0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (v.alu % 4) != 0;
`endif
        if (mis) begin
            v.exp_req    = 1'b0;
            v.exp_freeze = 1;
            v.exp_err    = 1'b1;
        end else begin
            v.exp_req    = 1'b1;
            v.exp_freeze = acked ? v.delay + 1 : TO + 1;
            v.exp_err    = !acked;
            if (acked && !v.w) model_result = v.rdata;
        end
        v.exp_result = model_result;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int   n;
        vec_t v;

        MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; Val_Rm = 0;
        mem_ack = 0; mem_rdata = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle for 10 cycles: no stall, no request, everything at reset value.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (freeze !== 1'b0 || mem_req !== 1'b0) begin
                check("idle_freeze_req", {30'b0, freeze, mem_req}, 32'd0);
            end
        end
        check("idle_freeze", {31'b0, freeze}, 32'd0);
        check("idle_req", {31'b0, mem_req}, 32'd0);
        check("idle_outputs", {15'b0, mem_we, mem_addr} | mem_wdata | MEM_result | {31'b0, mem_err}, 32'd0);
        check("idle_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});

        //          r  w  alu     val           dly rdata         req addr        we wdata         result        err frz
        tbl[0] = '{1, 0, 1032,   0,            3,  32'hDEADBEEF, 1, 2,          0, 0,            32'hDEADBEEF, 0, 4};
        tbl[1] = '{0, 1, 1028,   32'h12345678, 1,  32'h0BADF00D, 1, 1,          1, 32'h12345678, 32'hDEADBEEF, 0, 2};
        tbl[2] = '{1, 0, 1040,   0,            0,  32'h11111111, 1, 4,          0, 0,            32'hDEADBEEF, 1, 5};
        tbl[3] = '{1, 1, 1036,   32'h000000AA, 2,  32'h55555555, 1, 3,          1, 32'h000000AA, 32'hDEADBEEF, 0, 3};
        tbl[4] = '{1, 0, 1020,   0,            4,  32'hCAFEF00D, 1, 32'hFFFF,   0, 0,            32'hCAFEF00D, 0, 5};
        tbl[5] = '{1, 0, 0,      32'h77,       1,  32'h00000001, 1, 32'hFF00,   0, 32'h77,       32'h00000001, 0, 2};
        for (int i = 0; i < 6; i++) begin
            run_access(tbl[i], $sformatf("vec%0d", i));
        end
        model_result = 32'h00000001;

        // A stray ack while idle must be ignored.
        @(negedge clk) mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
        check("stray_ack_result", MEM_result, model_result);

        // Reset two cycles into a request, then a late ack.
        @(posedge clk); #1 MEM_R_EN = 1'b1; ALU_result = 32'd1032;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check("rst_req_seen", {31'b0, mem_req}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req_async", {31'b0, mem_req}, 32'd0);
        check("rst_state_async", {30'b0, fsm_state}, {30'b0, ST_IDLE});
        MEM_R_EN = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) mem_ack = 1'b1; mem_rdata = 32'h99999999;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        check("late_ack_result", MEM_result, 32'd0);
        check("late_ack_err", {31'b0, mem_err}, 32'd0);
        model_result = 32'd0;

`ifdef MEM_ALIGN_CHECK_EN
        v = '{1, 0, 1026, 0, 1, 32'h12121212, 0, 0, 0, 0, 32'd0, 1, 1};
        run_access(v, "align");
`endif

        for (int i = 0; i < 40; i++) begin
            v = make_random();
            run_access(v, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
